// File: rtl/cpu_exec_unit.sv
// Datapath of the 16-bit CPU: PC, IR, 8x16 register file, ALU and memory address/data selection.
// All sequencing comes from the control unit's control word; flags are returned raw, unlatched.
module cpu_exec_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    W_Adr,
    input  logic [2:0]    R_Adr,
    input  logic [2:0]    S_Adr,
    input  logic          adr_sel,
    input  logic          s_sel,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic          ir_ld,
    input  logic          rw_en,
    input  logic          mw_en,
    input  logic [3:0]    alu_op,
    input  logic [W-1:0]  D_in,
    output logic [W-1:0]  Addr,
    output logic [W-1:0]  D_out,
    output logic [W-1:0]  IR,
    output logic [W-1:0]  PC,
    output logic          N,
    output logic          Z,
    output logic          C
);

    logic [W-1:0] r_regs [8];
    logic [W-1:0] r_pc;
    logic [W-1:0] r_ir;

    logic [W-1:0] w_rbus;
    logic [W-1:0] w_sbus;
    logic [W-1:0] w_wbus;
    logic [W:0]   w_alu_full;
    logic [W-1:0] w_alu_out;
    logic [W-1:0] w_wb_data;
    logic [W-1:0] w_pc_rel;

    assign w_rbus = r_regs[R_Adr];
    assign w_sbus = r_regs[S_Adr];
    assign w_wbus = r_regs[W_Adr];

    // Bit W of the 17-bit result carries carry, borrow or the shifted-out bit.
    always_comb begin
        w_alu_full = {1'b0, w_sbus};
        case (alu_op)
            4'b0010:          w_alu_full = {1'b0, w_sbus} + 17'd1;
            4'b0011:          w_alu_full = {1'b0, w_sbus} - 17'd1;
            4'b0100:          w_alu_full = {1'b0, w_rbus} + {1'b0, w_sbus};
            4'b0101, 4'b1000: w_alu_full = {1'b0, w_rbus} - {1'b0, w_sbus};
            4'b0110:          w_alu_full = {w_sbus[0], 1'b0, w_sbus[W-1:1]};
            4'b0111:          w_alu_full = {w_sbus[W-1], w_sbus[W-2:0], 1'b0};
            default:          w_alu_full = {1'b0, w_sbus};
        endcase
    end

    assign w_alu_out = w_alu_full[W-1:0];
    assign N         = w_alu_out[W-1];
    assign Z         = (w_alu_out == '0);
    assign C         = w_alu_full[W];

    assign w_wb_data = s_sel ? D_in : w_alu_out;
    assign w_pc_rel  = r_pc + {{8{r_ir[7]}}, r_ir[7:0]};

    // Stores address memory through W_Adr, loads through S_Adr.
    assign Addr  = !adr_sel ? r_pc : (mw_en ? w_wbus : w_sbus);
    assign D_out = w_sbus;
    assign IR    = r_ir;
    assign PC    = r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (rw_en) begin
            r_regs[W_Adr] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else if (pc_ld) begin
            r_pc <= pc_sel ? w_sbus : w_pc_rel;
        end else if (pc_inc) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= '0;
        end else if (ir_ld) begin
            r_ir <= D_in;
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed bench for cpu_exec_unit: reset, register writes, ALU ops/flags, PC update and address select.
module tb_cpu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en, mw_en;
    logic [3:0]  alu_op;
    logic [15:0] D_in;
    logic [15:0] Addr, D_out, IR, PC;
    logic        N, Z, C;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_exec_unit #(.PC_RESET(16'h0000), .W(16)) dut (
        .clk(clk), .reset(reset),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .mw_en(mw_en),
        .alu_op(alu_op), .D_in(D_in),
        .Addr(Addr), .D_out(D_out), .IR(IR), .PC(PC),
        .N(N), .Z(Z), .C(C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic en, input logic ez, input logic ec);
        chk(tag, {13'd0, N, Z, C}, {13'd0, en, ez, ec});
    endtask

    task automatic idle();
        W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
        adr_sel = 0; s_sel = 0; pc_ld = 0; pc_inc = 0; pc_sel = 0;
        ir_ld = 0; rw_en = 0; mw_en = 0; alu_op = 4'd0; D_in = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] v);
        idle();
        rw_en = 1; s_sel = 1; W_Adr = a; D_in = v;
        step();
        idle();
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] v);
        S_Adr = a;
        #1;
        chk(tag, D_out, v);
    endtask

    initial begin
        idle();
        reset = 0;
        // Reset holds state even with fetch controls active.
        D_in = 16'h1234; ir_ld = 1; pc_inc = 1;
        step();
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_addr", Addr, 16'h0000);
        reset = 1;
        step();
        chk("fetch_ir", IR, 16'h1234);
        chk("fetch_pc", PC, 16'h0001);
        idle();
        chk_reg("rst_r0", 3'd0, 16'h0000);
        chk_reg("rst_r7", 3'd7, 16'h0000);

        // INC through 7FFF -> 8000
        wr_reg(3'd3, 16'h7FFF);
        alu_op = 4'b0010; S_Adr = 3'd3; W_Adr = 3'd4; rw_en = 1;
        #1;
        chk_flags("inc_flags", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        chk_reg("inc_r4", 3'd4, 16'h8000);

        // ADD with carry out to zero, CMP, SUB with borrow
        wr_reg(3'd1, 16'hFFFF);
        wr_reg(3'd2, 16'h0001);
        alu_op = 4'b0100; R_Adr = 3'd1; S_Adr = 3'd2;
        #1;
        chk_flags("add_flags", 1'b0, 1'b1, 1'b1);
        alu_op = 4'b1000;
        #1;
        chk_flags("cmp_flags", 1'b1, 1'b0, 1'b0);
        step();
        chk_reg("cmp_r1", 3'd1, 16'hFFFF);
        chk_reg("cmp_r2", 3'd2, 16'h0001);
        chk_reg("cmp_r3", 3'd3, 16'h7FFF);
        chk_reg("cmp_r4", 3'd4, 16'h8000);
        alu_op = 4'b0101; R_Adr = 3'd2; S_Adr = 3'd1; W_Adr = 3'd5; rw_en = 1;
        #1;
        chk_flags("sub_flags", 1'b0, 1'b0, 1'b1);
        step();
        idle();
        chk_reg("sub_r5", 3'd5, 16'h0002);
        alu_op = 4'b0011; S_Adr = 3'd0;
        #1;
        chk_flags("dec0_flags", 1'b1, 1'b0, 1'b1);

        // Relative branch with PC load taking priority over increment
        idle();
        wr_reg(3'd5, 16'hABCD);
        wr_reg(3'd7, 16'h0010);
        ir_ld = 1; D_in = 16'hF9FE;
        step();
        chk("br_ir", IR, 16'hF9FE);
        idle();
        pc_ld = 1; pc_sel = 1; S_Adr = 3'd7;
        step();
        chk("pc_abs10", PC, 16'h0010);
        pc_sel = 0; pc_inc = 1;
        step();
        chk("pc_rel", PC, 16'h000E);
        pc_sel = 1; S_Adr = 3'd5;
        step();
        chk("pc_abs", PC, 16'hABCD);

        // PC wrap and address select
        idle();
        pc_ld = 1; pc_sel = 1; S_Adr = 3'd1;
        step();
        idle();
        chk("pc_ffff", Addr, 16'hFFFF);
        pc_inc = 1;
        step();
        chk("pc_wrap", PC, 16'h0000);
        wr_reg(3'd6, 16'h0040);
        adr_sel = 1; mw_en = 1; W_Adr = 3'd6; S_Adr = 3'd3;
        #1;
        chk("sto_addr", Addr, 16'h0040);
        chk("sto_dout", D_out, 16'h7FFF);
        mw_en = 0; S_Adr = 3'd2;
        #1;
        chk("ld_addr", Addr, 16'h0001);

        // LDI: register load from memory and PC++ on the same edge
        idle();
        s_sel = 1; pc_inc = 1; rw_en = 1; W_Adr = 3'd0; D_in = 16'h5A5A;
        step();
        idle();
        chk("ldi_pc", PC, 16'h0001);
        chk_reg("ldi_r0", 3'd0, 16'h5A5A);

        // Shifts and undefined opcode
        wr_reg(3'd2, 16'h8001);
        alu_op = 4'b0111; S_Adr = 3'd2; W_Adr = 3'd4; rw_en = 1;
        #1;
        chk_flags("shl_flags", 1'b0, 1'b0, 1'b1);
        step();
        idle();
        chk_reg("shl_r4", 3'd4, 16'h0002);
        wr_reg(3'd3, 16'h0003);
        alu_op = 4'b0110; S_Adr = 3'd3; W_Adr = 3'd4; rw_en = 1;
        #1;
        chk_flags("shr_flags", 1'b0, 1'b0, 1'b1);
        step();
        idle();
        chk_reg("shr_r4", 3'd4, 16'h0001);
        wr_reg(3'd7, 16'h0000);
        alu_op = 4'b1111; S_Adr = 3'd7;
        #1;
        chk_flags("op15_flags", 1'b0, 1'b1, 1'b0);
        alu_op = 4'b0000; S_Adr = 3'd2;
        #1;
        chk_flags("pass_flags", 1'b1, 1'b0, 1'b0);

        // Mid-cycle reset clears everything at once; no write on the release edge.
        idle();
        #2;
        reset = 0;
        #1;
        chk("mid_rst_pc", PC, 16'h0000);
        chk("mid_rst_ir", IR, 16'h0000);
        chk_reg("mid_rst_r2", 3'd2, 16'h0000);
        rw_en = 1; s_sel = 1; W_Adr = 3'd2; D_in = 16'hBEEF; ir_ld = 1; pc_inc = 1;
        step();
        chk_reg("rst_hold_r2", 3'd2, 16'h0000);
        chk("rst_hold_pc", PC, 16'h0000);
        reset = 1;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
